// File: rtl/pc_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl_if
// Groups the two handshakes around the fetch sequencer into one bundle:
//   imem side   : imem_req / imem_addr (fetch -> memory), imem_ack / imem_rdata
//                 (memory -> fetch)
//   decode side : if_valid / if_instr / if_pc (fetch -> decode), id_ready
//                 (decode -> fetch)
// Modports
//   master : the fetch sequencer (drives request and IF/ID payload)
//   slave  : the environment (instruction memory plus decode stage)
// -----------------------------------------------------------------------------
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// pc_fetch_ctrl
// Fetch sequencer: owns the program counter, issues instruction-memory
// requests (req held until ack) and presents the fetched word to decode
// through a valid/ready handshake. The PC advances by PC_STEP after each
// accepted instruction or is replaced by a redirect target.
//
// Ports
//   clk              system clock, all state on posedge
//   rst              synchronous reset, active-high
//   bus              pc_fetch_ctrl_if.master: imem req/addr/ack/rdata and
//                    if_valid/if_instr/if_pc/id_ready
//   redirect_valid_i load redirect_pc_i as next fetch PC
//   redirect_pc_i    redirect target
//   fetch_cnt_o      instructions accepted by decode (wraps modulo 2^32)
//   fetch_fault_o    sticky misaligned-redirect fault
//
// Optional feature (macro PC_ALIGN_CHECK_EN)
//   Defined  : a redirect with target[1:0] != 0 sets fetch_fault_o and parks
//              the FSM in S_FAULT until reset.
//   Undefined: no fault state; redirect targets are forced word-aligned and
//              fetch_fault_o is tied low.
// -----------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 32'd4
) (
  input  logic                   clk,
  input  logic                   rst,
  pc_fetch_ctrl_if.master        bus,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [31:0]            fetch_cnt_o,
  output logic                   fetch_fault_o
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2
  } state_t;
`endif

  // Clears the byte-offset bits of a redirect target.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        flush_q, flush_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q;
  logic        valid_q;
  logic [31:0] redir_tgt_s;
  logic        redir_bad_s;

  assign redir_tgt_s = word_align(redirect_pc_i);

`ifdef PC_ALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign redir_bad_s   = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
  assign fetch_fault_o = fault_q;
`else
  assign redir_bad_s   = 1'b0;
  assign fetch_fault_o = 1'b0;
`endif

  // Next-state and datapath decisions for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    redir_d = redir_q;
    flush_d = flush_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
`ifdef PC_ALIGN_CHECK_EN
        if (redir_bad_s) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else
`endif
        if (bus.imem_ack) begin
          // An ack ends the request; the word is only kept if nothing
          // redirected the fetch while it was outstanding.
          if (redirect_valid_i) begin
            pc_d    = redir_tgt_s;
            flush_d = 1'b0;
          end else if (flush_q) begin
            pc_d    = redir_q;
            flush_d = 1'b0;
          end else begin
            instr_d = bus.imem_rdata;
            state_d = S_HOLD;
          end
        end else if (redirect_valid_i) begin
          // Address must stay stable while req is up: park the target.
          redir_d = redir_tgt_s;
          flush_d = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        // The handshake counts even when a redirect lands in the same cycle.
        if (bus.id_ready) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          cnt_d = cnt_q;
        end
`ifdef PC_ALIGN_CHECK_EN
        if (redir_bad_s) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end else
`endif
        if (redirect_valid_i) begin
          pc_d    = redir_tgt_s;
          state_d = S_REQ;
        end else if (bus.id_ready) begin
          pc_d    = pc_q + STEP;
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      redir_q <= RESET_PC;
      flush_q <= 1'b0;
      instr_q <= 32'h0000_0000;
      cnt_q   <= 32'h0000_0000;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      redir_q <= redir_d;
      flush_q <= flush_d;
      instr_q <= instr_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == S_REQ);
      valid_q <= (state_d == S_HOLD);
`ifdef PC_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = valid_q;
  assign bus.if_instr  = instr_q;
  assign bus.if_pc     = pc_q;
  assign fetch_cnt_o   = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Scoreboard bench: expected request addresses and expected decode handshakes
// are queued as stimulus is driven; a negedge monitor pops and compares them.
// A memory responder acks each request after ack_delay extra cycles with a
// data word derived from the address. Inputs change #1 after posedge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] fetch_cnt;
  logic        fetch_fault;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.master),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .fetch_cnt_o      (fetch_cnt),
    .fetch_fault_o    (fetch_fault)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_delay;
  logic        mem_en;
  logic [31:0] exp_cnt;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_hs_q[$];

  // Monitor history
  logic        req_prev  = 1'b0;
  logic        ack_prev  = 1'b0;
  logic [31:0] addr_prev = 32'h0000_0000;
  int          req_len   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int budget = 50;
    while (bus.if_valid !== 1'b1 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_hs_empty(input string tag);
    int budget = 60;
    while (exp_hs_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Instruction memory: acks a request on its (ack_delay+1)-th cycle.
  initial begin
    int   wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        if (bus.imem_ack) wcnt = 0;
        if (bus.imem_req === 1'b1) begin
          if (wcnt >= ack_delay) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(bus.imem_addr);
          end else begin
            bus.imem_ack = 1'b0;
            wcnt++;
          end
        end else begin
          bus.imem_ack = 1'b0;
          wcnt = 0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.imem_req === 1'b1) begin
        if (!req_prev || ack_prev) begin
          req_len = 1;
          if (exp_addr_q.size() == 0) check("req_unexpected", bus.imem_addr, 32'hFFFF_FFFF);
          else check("req_addr", bus.imem_addr, exp_addr_q.pop_front());
        end else begin
          req_len++;
          check("addr_stable", bus.imem_addr, addr_prev);
        end
        check("valid_in_req", {31'd0, bus.if_valid}, 32'd0);
        if (bus.imem_ack === 1'b1 && mem_en) check("ack_latency", 32'(req_len), 32'(ack_delay + 1));
      end
      if (bus.if_valid === 1'b1 && bus.id_ready === 1'b1) begin
        if (exp_hs_q.size() == 0) begin
          check("hs_unexpected", bus.if_pc, 32'hFFFF_FFFF);
        end else begin
          logic [31:0] pc_e;
          pc_e = exp_hs_q.pop_front();
          check("hs_pc", bus.if_pc, pc_e);
          check("hs_instr", bus.if_instr, mem_word(pc_e));
        end
        exp_cnt = exp_cnt + 32'd1;
      end
      req_prev  = (bus.imem_req === 1'b1);
      ack_prev  = (bus.imem_ack === 1'b1);
      addr_prev = bus.imem_addr;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_req"},    {31'd0, bus.imem_req}, 32'd0);
    check({tag, "_addr"},   bus.imem_addr, 32'h0000_0000);
    check({tag, "_valid"},  {31'd0, bus.if_valid}, 32'd0);
    check({tag, "_if_pc"},  bus.if_pc, 32'h0000_0000);
    check({tag, "_cnt"},    fetch_cnt, 32'd0);
    check({tag, "_fault"},  {31'd0, fetch_fault}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;  redirect_valid = 1'b0;  redirect_pc = 32'h0;
    bus.id_ready = 1'b0;  bus.imem_ack = 1'b0;  bus.imem_rdata = 32'h0;
    mem_en = 1'b1;  ack_delay = 1;  exp_cnt = 32'd0;

    // Reset state
    tick(2);
    check_reset_state("rst");
    check("rst_instr", bus.if_instr, 32'h0000_0000);

    // 1: sequential fetch, ack one cycle after req, decode always ready
    exp_addr_q.push_back(32'h0);  exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);  exp_addr_q.push_back(32'hC);
    exp_hs_q.push_back(32'h0);  exp_hs_q.push_back(32'h4);  exp_hs_q.push_back(32'h8);
    bus.id_ready = 1'b1;
    rst = 1'b0;
    wait_hs_empty("t1");
    bus.id_ready = 1'b0;
    check("t1_cnt", fetch_cnt, 32'd3);

    // 2: ack delayed 3 cycles, request held stable
    wait_valid("t2a");
    ack_delay = 3;
    exp_hs_q.push_back(32'hC);  exp_addr_q.push_back(32'h10);
    bus.id_ready = 1'b1;
    tick(1);
    bus.id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_req",   {31'd0, bus.imem_req}, 32'd1);
      check("t2_addr",  bus.imem_addr, 32'h10);
      check("t2_valid", {31'd0, bus.if_valid}, 32'd0);
      tick(1);
    end
    check("t2_valid_after", {31'd0, bus.if_valid}, 32'd1);
    check("t2_if_pc", bus.if_pc, 32'h10);

    // 3: redirect during an unacked request drops that word
    exp_hs_q.push_back(32'h10);
    exp_addr_q.push_back(32'h14);  exp_addr_q.push_back(32'h100);
    exp_hs_q.push_back(32'h100);   exp_addr_q.push_back(32'h104);
    bus.id_ready = 1'b1;
    tick(1);
    redirect_valid = 1'b1;  redirect_pc = 32'h100;
    tick(1);
    redirect_valid = 1'b0;
    wait_hs_empty("t3");
    bus.id_ready = 1'b0;

    // 4: decode stalls, then a redirect drops the held word
    wait_valid("t4a");
    for (int i = 0; i < 5; i++) begin
      check("t4_valid", {31'd0, bus.if_valid}, 32'd1);
      check("t4_if_pc", bus.if_pc, 32'h104);
      check("t4_cnt",   fetch_cnt, exp_cnt);
      tick(1);
    end
    ack_delay = 0;
    exp_addr_q.push_back(32'h40);
    redirect_valid = 1'b1;  redirect_pc = 32'h40;
    tick(1);
    redirect_valid = 1'b0;
    check("t4_valid_drop", {31'd0, bus.if_valid}, 32'd0);
    check("t4_cnt_after",  fetch_cnt, exp_cnt);

    // 5: handshake and redirect in the same cycle
    wait_valid("t5a");
    exp_hs_q.push_back(32'h40);  exp_addr_q.push_back(32'h80);
    bus.id_ready = 1'b1;  redirect_valid = 1'b1;  redirect_pc = 32'h80;
    tick(1);
    bus.id_ready = 1'b0;  redirect_valid = 1'b0;
    check("t5_cnt",  fetch_cnt, exp_cnt);
    check("t5_addr", bus.imem_addr, 32'h80);

    // 6: misaligned redirect
    wait_valid("t6a");
`ifdef PC_ALIGN_CHECK_EN
    redirect_valid = 1'b1;  redirect_pc = 32'h102;
    tick(1);
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t6_fault", {31'd0, fetch_fault}, 32'd1);
      check("t6_req",   {31'd0, bus.imem_req}, 32'd0);
      check("t6_valid", {31'd0, bus.if_valid}, 32'd0);
      tick(1);
    end
`else
    exp_addr_q.push_back(32'h100);
    redirect_valid = 1'b1;  redirect_pc = 32'h102;
    tick(1);
    redirect_valid = 1'b0;
    check("t6_addr",  bus.imem_addr, 32'h100);
    check("t6_fault", {31'd0, fetch_fault}, 32'd0);
    wait_valid("t6b");
    check("t6_if_pc", bus.if_pc, 32'h100);
`endif

    // Reset, then PC wrap at the top of the address space
    rst = 1'b1;
    tick(2);
    exp_cnt = 32'd0;
    check_reset_state("rst2");
    exp_addr_q.push_back(32'h0);
    rst = 1'b0;
    wait_valid("wrap_a");
    exp_addr_q.push_back(32'hFFFF_FFFC);
    redirect_valid = 1'b1;  redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect_valid = 1'b0;
    wait_valid("wrap_b");
    check("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
    exp_hs_q.push_back(32'hFFFF_FFFC);  exp_addr_q.push_back(32'h0);
    bus.id_ready = 1'b1;
    wait_hs_empty("wrap");
    bus.id_ready = 1'b0;
    check("wrap_addr", bus.imem_addr, 32'h0);
    check("wrap_cnt",  fetch_cnt, exp_cnt);

    // Reset mid-request: a late ack must be ignored and RESET_PC refetched
    wait_valid("mid_a");
    ack_delay = 3;
    exp_hs_q.push_back(32'h0);  exp_addr_q.push_back(32'h4);
    bus.id_ready = 1'b1;
    tick(1);
    bus.id_ready = 1'b0;
    tick(1);
    rst = 1'b1;  mem_en = 1'b0;  bus.imem_ack = 1'b0;
    tick(1);
    exp_cnt = 32'd0;
    check_reset_state("mid_rst");
    rst = 1'b0;
    bus.imem_ack = 1'b1;  bus.imem_rdata = 32'hBAD0_BAD0;
    exp_addr_q.push_back(32'h0);
    @(negedge clk);
    mem_en = 1'b1;
    tick(1);
    check("mid_req",  {31'd0, bus.imem_req}, 32'd1);
    check("mid_addr", bus.imem_addr, 32'h0);
    exp_hs_q.push_back(32'h0);  exp_addr_q.push_back(32'h4);
    bus.id_ready = 1'b1;
    wait_hs_empty("mid");
    bus.id_ready = 1'b0;
    check("mid_cnt", fetch_cnt, exp_cnt);
    wait_valid("mid_b");
    check("mid_if_pc", bus.if_pc, 32'h4);

    check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    check("hs_q_empty",   32'(exp_hs_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
